// File: rtl/ram_fifo_pkg.sv
// Shared parameters and types for the RAM-backed byte FIFO controller.
// Optional feature macro: RAM_FIFO_BYPASS_EN (direct push-to-output bypass).
package ram_fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned CNT_W  = 6;

  // Occupancy value at which the RAM holds DEPTH bytes.
  localparam logic [CNT_W-1:0] RAM_FULL = CNT_W'(DEPTH);

  // Owner of the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  // Returns the value for the single RAM port owner given both request lines.
  // Read always wins.
  function automatic gnt_e pick_grant(input logic rd, input logic wr);
    gnt_e g;
    g = GNT_NONE;
    if (rd) begin
      g = GNT_RD;
    end else if (wr) begin
      g = GNT_WR;
    end
    return g;
  endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM address pointer with increment enable and synchronous
// active-low reset. Wraps from DEPTH-1 back to 0.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Next pointer: advance by one when enabled; modulo wrap is implicit.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO controller driving an external 32x8 single-port RAM, with a
// registered output stage in front of the consumer (capacity 33 bytes).
// Optional feature macro: RAM_FIFO_BYPASS_EN -- a push into an otherwise
// empty queue loads the output register directly, skipping the RAM.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [CNT_W-1:0]  count,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              rd_g;
  logic              wr_g;
  logic              byp_g;
  logic              ram_wr;
  logic              push_rdy;
  gnt_e              gnt;

  ram_fifo_ptr u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ram_wr),
    .ptr   (wr_ptr)
  );

  ram_fifo_ptr u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_g),
    .ptr   (rd_ptr)
  );

  // Port arbitration: refill the output stage first, accept a push otherwise.
  // Everything is gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    rd_g     = rst_n && (ram_cnt_q != '0) && (!out_valid_q || pop_ready);
    push_rdy = rst_n && (ram_cnt_q != RAM_FULL) && !rd_g;
    wr_g     = push_valid && push_rdy;
`ifdef RAM_FIFO_BYPASS_EN
    byp_g    = wr_g && (ram_cnt_q == '0) && (!out_valid_q || pop_ready);
`else
    byp_g    = 1'b0;
`endif
    ram_wr   = wr_g && !byp_g;
    gnt      = pick_grant(rd_g, ram_wr);
  end

  // RAM port drive; address idles on rd_ptr so the read data is always ready.
  always_comb begin
    ram_wena  = 1'b0;
    ram_addr  = rd_ptr;
    ram_wdata = push_data;
    case (gnt)
      GNT_RD:  ram_addr = rd_ptr;
      GNT_WR: begin
        ram_wena = 1'b1;
        ram_addr = wr_ptr;
      end
      default: ram_addr = rd_ptr;
    endcase
  end

  // Next-state for RAM occupancy and the output register.
  always_comb begin
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (rd_g) begin
      ram_cnt_d = ram_cnt_q - CNT_W'(1);
    end else if (ram_wr) begin
      ram_cnt_d = ram_cnt_q + CNT_W'(1);
    end
    if (rd_g) begin
      out_data_d  = ram_rdata;
      out_valid_d = 1'b1;
    end else if (byp_g) begin
      out_data_d  = push_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && pop_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign push_ready = push_rdy;
  assign pop_valid  = out_valid_q;
  assign pop_data   = out_data_q;
  assign count      = ram_cnt_q + CNT_W'(out_valid_q);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 32x8 RAM and a
// scoreboard queue of accepted bytes.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic       pop_ready;
  logic [5:0] count;
  logic       ram_wena;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  logic [7:0] mem [32];

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference state
  int         m_cnt;
  logic       m_ov;
  logic       m_acc;
  logic [7:0] sb[$];
  logic       seen_pv;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wena) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  ram_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .count      (count),
    .ram_wena   (ram_wena),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational and registered
  // outputs against the reference, then advance the reference.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic pr);
    logic m_rd, exp_prdy, m_byp;
    @(negedge clk);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    #1;
    m_rd     = (m_cnt != 0) && (!m_ov || pr);
    exp_prdy = (m_cnt != 32) && !m_rd;
    m_acc    = pv && exp_prdy;
`ifdef RAM_FIFO_BYPASS_EN
    m_byp    = m_acc && (m_cnt == 0) && (!m_ov || pr);
`else
    m_byp    = 1'b0;
`endif
    seen_pv = pop_valid;
    check("push_ready", {7'd0, push_ready}, {7'd0, exp_prdy});
    check("pop_valid", {7'd0, pop_valid}, {7'd0, m_ov});
    check("count", {2'd0, count}, 8'(m_cnt + int'(m_ov)));
    check("ram_wena", {7'd0, ram_wena}, {7'd0, m_acc && !m_byp});
    if (m_ov) begin
      if (sb.size() == 0) check("sb_underflow", 8'd1, 8'd0);
      else check("pop_data", pop_data, sb[0]);
    end
    if (m_ov && pr) void'(sb.pop_front());
    if (m_acc) sb.push_back(pd);
    if (m_rd) begin
      m_ov  = 1'b1;
      m_cnt = m_cnt - 1;
    end else if (m_byp) begin
      m_ov = 1'b1;
    end else if (m_ov && pr) begin
      m_ov = 1'b0;
    end
    if (m_acc && !m_byp) m_cnt = m_cnt + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'hA5;
    pop_ready  = 1'b1;
    #1;
    check("rst_push_ready", {7'd0, push_ready}, 8'd0);
    check("rst_ram_wena", {7'd0, ram_wena}, 8'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #1;
    check("rst_count", {2'd0, count}, 8'd0);
    check("rst_pop_valid", {7'd0, pop_valid}, 8'd0);
    check("rst_pop_data", pop_data, 8'h00);
    m_cnt = 0;
    m_ov  = 1'b0;
    sb.delete();
  endtask

  task automatic push_seq(input int n, input logic [7:0] base, input logic pr);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      m_acc = 1'b0;
      while (!m_acc && b < 100) begin
        cycle(1'b1, base + 8'(i), pr);
        b++;
      end
      if (!m_acc) check("push_timeout", 8'd1, 8'd0);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || m_ov) && b < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      b++;
    end
    check("drain_empty", 8'(sb.size()), 8'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("drain_count", {2'd0, count}, 8'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; push_valid = 1'b0; push_data = 8'h00; pop_ready = 1'b0;
    m_cnt = 0; m_ov = 1'b0; m_acc = 1'b0; seen_pv = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    // Single byte latency
    cycle(1'b1, 8'h9F, 1'b1);
    lat = 0;
    seen_pv = 1'b0;
    while (!seen_pv && lat < 10) begin
      cycle(1'b0, 8'h00, 1'b1);
      lat++;
    end
`ifdef RAM_FIFO_BYPASS_EN
    check("latency", 8'(lat), 8'd1);
`else
    check("latency", 8'(lat), 8'd2);
`endif
    drain();

    // Fill to 33, 34th refused, drain in order
    push_seq(33, 8'h00, 1'b0);
    cycle(1'b1, 8'h21, 1'b0);
    cycle(1'b1, 8'h21, 1'b0);
    check("full_count", {2'd0, count}, 8'd33);
    check("full_push_ready", {7'd0, push_ready}, 8'd0);
    check("full_sb", 8'(sb.size()), 8'd33);
    drain();

    // Streaming across pointer wrap
    push_seq(40, 8'h40, 1'b1);
    drain();

    // Output held while consumer stalls
    push_seq(2, 8'hC0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    check("stall_pop_data", pop_data, 8'hC0);
    drain();

    // Reset with 12 bytes queued
    push_seq(12, 8'h70, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("pre_rst_count", {2'd0, count}, 8'd12);
    do_reset();
    push_seq(1, 8'hFF, 1'b1);
    drain();

    // Read wins over write, push accepted the following cycle
    push_seq(3, 8'h30, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hE1, 1'b1);
    check("rd_wins", {7'd0, m_acc}, 8'd0);
    cycle(1'b1, 8'hE1, 1'b0);
    check("push_after_rd", {7'd0, m_acc}, 8'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 push_valid  input  1  producer offers push_data.
REQ-004 push_data  input  8  byte to enqueue.
REQ-005 push_ready  output  1  controller accepts push_data this cycle.
REQ-006 pop_valid  output  1  pop_data holds the oldest byte.
REQ-007 pop_data  output  8  head-of-queue byte, registered.
REQ-008 pop_ready  input  1  consumer takes pop_data this cycle.
REQ-009 count  output  6  bytes held, 0..33 (RAM entries plus output register).
REQ-010 ram_wena  output  1  write enable to the 32x8 single-port RAM.
REQ-011 ram_addr  output  5  RAM address.
REQ-012 ram_wdata  output  8  RAM write data.
REQ-013 ram_rdata  input  8  RAM read data; combinational function of ram_addr; RAM writes on rising clk when ram_wena=1.

Function
REQ-014 Internal state: wr_ptr[4:0], rd_ptr[4:0], ram_cnt[5:0] (0..32), out_valid, out_data[7:0]; pop_valid=out_valid, pop_data=out_data, count=ram_cnt+out_valid.
REQ-015 Single RAM port: at most one RAM access per cycle, either a read grant (rd_g) or a write grant (wr_g).
REQ-016 rd_g = (ram_cnt!=0) && (!out_valid || pop_ready); read has priority over write.
REQ-017 push_ready = (ram_cnt!=32) && !rd_g; combinational path pop_ready->push_ready is permitted.
REQ-018 wr_g = push_valid && push_ready.
REQ-019 On rd_g: ram_addr=rd_ptr, ram_wena=0; out_data<=ram_rdata, out_valid<=1, rd_ptr<=rd_ptr+1, ram_cnt decrements.
REQ-020 On wr_g: ram_addr=wr_ptr, ram_wena=1, ram_wdata=push_data; wr_ptr<=wr_ptr+1, ram_cnt increments.
REQ-021 No grant: ram_wena=0, ram_addr=rd_ptr, ram_wdata=push_data.
REQ-022 pop_valid && pop_ready without rd_g: out_valid<=0.
REQ-023 Pointers wrap 31->0 modulo 32; data order is strictly FIFO across wrap.
REQ-024 Full (ram_cnt=32): push_ready=0 and push_data is dropped from consideration; no overwrite.
REQ-025 Empty (count=0): pop_valid=0; pop_ready is ignored.
REQ-026 pop_valid stays high and pop_data stays stable until pop_ready is sampled high.
REQ-027 Latency without bypass: push accepted in cycle N -> pop_valid in cycle N+2 when the queue was empty.

Reset
REQ-028 rst_n=0 at a rising edge: wr_ptr=0, rd_ptr=0, ram_cnt=0, out_valid=0, out_data=8'h00; count=0, pop_valid=0, pop_data=8'h00.
REQ-029 ram_wena=0 and push_ready=0 while rst_n=0, independent of other inputs.
REQ-030 Reset mid-operation discards all queued bytes; RAM contents are not cleared and are never read as valid data after reset.

Configuration
REQ-031 Macro RAM_FIFO_BYPASS_EN: when defined, a push with ram_cnt=0 and (!out_valid || pop_ready) loads out_data directly (no RAM write, ram_wena=0); push-to-pop_valid latency is 1 cycle.
REQ-032 Without RAM_FIFO_BYPASS_EN, every byte passes through the RAM per REQ-027.

Structure
REQ-033 Package ram_fifo_pkg holds DATA_W=8, ADDR_W=5, DEPTH=32, and CNT_W=6.
REQ-034 Sub-module ram_fifo_ptr (5-bit wrapping pointer with increment enable and synchronous active-low reset) is instantiated twice, once for wr_ptr and once for rd_ptr; the RAM is instantiated outside this block.

Verification
REQ-035 Reset then push 8'h9F, pop_ready=1 -> pop_data=8'h9F with pop_valid in cycle N+2 (N+1 with bypass); count returns to 0.
REQ-036 Push 33 bytes 8'h00..8'h20 with pop_ready=0 -> count=33, push_ready=0; 34th byte not accepted; draining yields 8'h00..8'h20 in order.
REQ-037 Push 40 bytes while popping continuously -> pointers wrap past 31; output sequence equals input sequence; ram_wena and a read grant are never active in the same cycle.
REQ-038 pop_ready held 0 for 5 cycles with pop_valid=1 -> pop_data unchanged across all 5 cycles.
REQ-039 Assert rst_n=0 for 1 cycle with count=12 -> next cycle count=0, pop_valid=0; a subsequent push 8'hFF pops as 8'hFF.
REQ-040 With pop_valid=1 and ram_cnt>0, pop_ready=1 and push_valid=1 -> push_ready=0 that cycle (read wins); push accepted on the next cycle.
